// File: rtl/facto_core_out_seq_if.sv
// facto_core_out_seq_if
// Bundles the register-bus port and the multiplier req/ack port of the
// factorial output/sequencing stage.
//   slave  : view of the core (bus slave, multiplier requester)
//   master : view of the host / multiplier model driving the core
// Signals
//   s_sel, s_wr, s_addr, s_din  : host -> core access (1-cycle strobe)
//   s_dout, s_rvalid            : core -> host read data, one cycle after the read
//   mul_req, mul_a, mul_b       : core -> multiplier request, held until ack
//   mul_ack, mul_res_h/l        : multiplier -> core completion with product
interface facto_core_out_seq_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              s_sel;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s_dout;
  logic              s_rvalid;
  logic              mul_req;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic              mul_ack;
  logic [DATA_W-1:0] mul_res_h;
  logic [DATA_W-1:0] mul_res_l;

  modport slave (
    input  s_sel, s_wr, s_addr, s_din, mul_ack, mul_res_h, mul_res_l,
    output s_dout, s_rvalid, mul_req, mul_a, mul_b
  );

  modport master (
    output s_sel, s_wr, s_addr, s_din, mul_ack, mul_res_h, mul_res_l,
    input  s_dout, s_rvalid, mul_req, mul_a, mul_b
  );
endinterface

// File: rtl/facto_core_out_seq.sv
// facto_core_out_seq
// Output/sequencing stage of the factorial core. Holds operand, result and
// status registers and walks N*(N-1)*...*2 through an external multiplier
// using a req/ack handshake. Register reads return one cycle after the access.
// Ports
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low reset
//   bus      : facto_core_out_seq_if.slave (register bus + multiplier port)
//   busy     : sequence in progress (state not IDLE/DONE)
//   intr     : done interrupt
// Register map
//   0 opstart (W bit0)  1 opclear (W bit0)  2 opdone (R: bit1 ovf, bit0 done)
//   3 intr_en (RW bit0) 4 operand (RW)      5 result_h (R)  6 result_l (R)
// Build option
//   FACTO_INTR_EN defined   : intr_en register present, intr = done & intr_en
//   FACTO_INTR_EN undefined : intr tied low, address 3 reads 0 / ignores writes
module facto_core_out_seq #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  facto_core_out_seq_if.slave  bus,
  output logic                 busy,
  output logic                 intr
);

  localparam logic [ADDR_W-1:0] A_OPSTART = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_OPCLEAR = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_OPDONE  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_INTR_EN = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_OPERAND = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_RES_H   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_RES_L   = ADDR_W'(6);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] res_h_q, res_h_d;
  logic [DATA_W-1:0] res_l_q, res_l_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              mul_req_q, mul_req_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d;
  logic [DATA_W-1:0] mul_b_q, mul_b_d;
  logic [DATA_W-1:0] s_dout_q, s_dout_d;
  logic              s_rvalid_q, s_rvalid_d;
`ifdef FACTO_INTR_EN
  logic              intr_en_q, intr_en_d;
  logic              intr_q, intr_d;
`endif

  logic              wr_en, rd_en, opstart, opclear;
  logic [DATA_W-1:0] cnt_dec;
  logic [DATA_W-1:0] rdata;

  assign wr_en   = bus.s_sel & bus.s_wr;
  assign rd_en   = bus.s_sel & ~bus.s_wr;
  assign opstart = wr_en && (bus.s_addr == A_OPSTART) && bus.s_din[0];
  assign opclear = wr_en && (bus.s_addr == A_OPCLEAR) && bus.s_din[0];
  assign cnt_dec = cnt_q - DATA_W'(1);

  // Read mux; write-only and unmapped addresses return 0.
  always_comb begin
    rdata = '0;
    case (bus.s_addr)
      A_OPDONE: rdata = {{(DATA_W-2){1'b0}}, ovf_q, done_q};
`ifdef FACTO_INTR_EN
      A_INTR_EN: rdata = {{(DATA_W-1){1'b0}}, intr_en_q};
`endif
      A_OPERAND: rdata = operand_q;
      A_RES_H:   rdata = res_h_q;
      A_RES_L:   rdata = res_l_q;
      default:   rdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_h_d    = res_h_q;
    res_l_d    = res_l_q;
    operand_d  = operand_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    mul_req_d  = mul_req_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    s_dout_d   = rd_en ? rdata : '0;
    s_rvalid_d = rd_en;
`ifdef FACTO_INTR_EN
    intr_en_d  = intr_en_q;
    intr_d     = intr_q;
    if (wr_en && (bus.s_addr == A_INTR_EN)) intr_en_d = bus.s_din[0];
`endif

    // The running sequence works from cnt, so operand may change freely.
    if (wr_en && (bus.s_addr == A_OPERAND)) operand_d = bus.s_din;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (opstart) begin
          state_d = S_LOAD;
          cnt_d   = operand_q;
          res_h_d = '0;
          res_l_d = DATA_W'(1);
          done_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD: begin
        // 0! and 1! are already 1; no multiply needed.
        if (cnt_q <= DATA_W'(1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Operands are latched here and stay stable while the request is up.
        mul_req_d = 1'b1;
        mul_a_d   = res_l_q;
        mul_b_d   = cnt_q;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mul_ack) begin
          mul_req_d = 1'b0;
          res_h_d   = bus.mul_res_h;
          res_l_d   = bus.mul_res_l;
          cnt_d     = cnt_dec;
          ovf_d     = ovf_q | (bus.mul_res_h != '0);
          if (cnt_dec == DATA_W'(1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear wins over everything, including an ack landing on the same edge.
    if (opclear) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      res_h_d   = '0;
      res_l_d   = '0;
      done_d    = 1'b0;
      ovf_d     = 1'b0;
      mul_req_d = 1'b0;
      mul_a_d   = '0;
      mul_b_d   = '0;
    end

`ifdef FACTO_INTR_EN
    intr_d = done_d & intr_en_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      res_h_q    <= '0;
      res_l_q    <= '0;
      operand_q  <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      mul_req_q  <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      s_dout_q   <= '0;
      s_rvalid_q <= 1'b0;
`ifdef FACTO_INTR_EN
      intr_en_q  <= 1'b0;
      intr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      res_h_q    <= res_h_d;
      res_l_q    <= res_l_d;
      operand_q  <= operand_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      mul_req_q  <= mul_req_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      s_dout_q   <= s_dout_d;
      s_rvalid_q <= s_rvalid_d;
`ifdef FACTO_INTR_EN
      intr_en_q  <= intr_en_d;
      intr_q     <= intr_d;
`endif
    end
  end

  assign bus.s_dout   = s_dout_q;
  assign bus.s_rvalid = s_rvalid_q;
  assign bus.mul_req  = mul_req_q;
  assign bus.mul_a    = mul_a_q;
  assign bus.mul_b    = mul_b_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
`ifdef FACTO_INTR_EN
  assign intr         = intr_q;
`else
  assign intr         = 1'b0;
`endif

endmodule

// File: tb/tb_facto_core_out_seq.sv
// Directed bench for facto_core_out_seq. Inputs change on the falling edge,
// outputs are sampled on the falling edge. A multiplier model answers
// mul_req after a programmable number of extra wait cycles.
module tb_facto_core_out_seq;
  localparam int DW = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy, intr;

  facto_core_out_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  facto_core_out_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave),
    .busy   (busy),
    .intr   (intr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit          ack_en = 1'b1;
  bit          force_ack = 1'b0;
  int          lat = 0;
  int          lat_cnt = 0;
  logic [63:0] inject_h = '0;
  logic [63:0] aq[$];
  logic [63:0] bq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Multiplier model: acts 1 time unit after the falling edge so that
  // flags changed by the main process on that edge are already visible.
  initial begin
    logic [127:0] p;
    bus.mul_ack   = 1'b0;
    bus.mul_res_h = '0;
    bus.mul_res_l = '0;
    forever begin
      @(negedge clk);
      #1;
      bus.mul_ack = 1'b0;
      if (force_ack) begin
        bus.mul_ack   = 1'b1;
        bus.mul_res_h = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.mul_res_l = 64'h0000_0000_0000_DEAD;
      end else if (bus.mul_req && ack_en) begin
        if (lat_cnt == lat) begin
          p = {64'd0, bus.mul_a} * {64'd0, bus.mul_b};
          bus.mul_res_h = (inject_h != '0) ? inject_h : p[127:64];
          bus.mul_res_l = p[63:0];
          bus.mul_ack   = 1'b1;
          aq.push_back(bus.mul_a);
          bq.push_back(bus.mul_b);
          lat_cnt = 0;
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // All bus tasks start and end just after a falling edge.
  task automatic wr(input logic [AW-1:0] a, input logic [63:0] d);
    bus.s_sel = 1'b1; bus.s_wr = 1'b1; bus.s_addr = a; bus.s_din = d;
    @(negedge clk);
    bus.s_sel = 1'b0; bus.s_wr = 1'b0; bus.s_din = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [63:0] exp);
    bus.s_sel = 1'b1; bus.s_wr = 1'b0; bus.s_addr = a;
    @(negedge clk);
    bus.s_sel = 1'b0;
    chk(tag, bus.s_dout, exp);
    chk({tag, "_rv"}, {63'd0, bus.s_rvalid}, 64'd1);
  endtask

  task automatic wait_idle(input int limit, output int cyc);
    cyc = 0;
    while (busy && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_req(input int limit);
    int cyc = 0;
    while (!bus.mul_req && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    chk("req_timeout", {63'd0, bus.mul_req}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [63:0] exp_a[4];
    exp_a[0] = 64'd1; exp_a[1] = 64'd5; exp_a[2] = 64'd20; exp_a[3] = 64'd60;
    bus.s_sel = 1'b0; bus.s_wr = 1'b0; bus.s_addr = '0; bus.s_din = '0;

    // Reset
    repeat (2) @(negedge clk);
    chk("rst_dout",   bus.s_dout, 64'd0);
    chk("rst_rvalid", {63'd0, bus.s_rvalid}, 64'd0);
    chk("rst_req",    {63'd0, bus.mul_req}, 64'd0);
    chk("rst_a",      bus.mul_a, 64'd0);
    chk("rst_b",      bus.mul_b, 64'd0);
    chk("rst_busy",   {63'd0, busy}, 64'd0);
    chk("rst_intr",   {63'd0, intr}, 64'd0);
    reset_n = 1'b1;
    rd_chk("rst_res_l", 5'd6, 64'd0);

    // 5! with one extra multiplier wait cycle: 1 + 4*(2+1) busy cycles
    lat = 1; aq.delete(); bq.delete();
    wr(5'd4, 64'd5);
    wr(5'd0, 64'd1);
    wait_idle(200, cyc);
    chk("f5_lat", 64'(cyc), 64'd13);
    chk("f5_nack", 64'(bq.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("f5_b%0d", i), (i < bq.size()) ? bq[i] : 64'hX, 64'(5 - i));
      chk($sformatf("f5_a%0d", i), (i < aq.size()) ? aq[i] : 64'hX, exp_a[i]);
    end
    rd_chk("f5_res_l",  5'd6, 64'd120);
    rd_chk("f5_res_h",  5'd5, 64'd0);
    rd_chk("f5_opdone", 5'd2, 64'd1);
    @(negedge clk);
    chk("rv_drop",   {63'd0, bus.s_rvalid}, 64'd0);
    chk("dout_drop", bus.s_dout, 64'd0);

    // 0! and 1!: no multiply, done two cycles after opstart
    lat = 0;
    for (int n = 0; n < 2; n++) begin
      bq.delete();
      wr(5'd4, 64'(n));
      wr(5'd0, 64'd1);
      chk($sformatf("f%0d_busy_load", n), {63'd0, busy}, 64'd1);
      chk($sformatf("f%0d_noreq", n), {63'd0, bus.mul_req}, 64'd0);
      @(negedge clk);
      chk($sformatf("f%0d_busy_done", n), {63'd0, busy}, 64'd0);
      rd_chk($sformatf("f%0d_opdone", n), 5'd2, 64'd1);
      rd_chk($sformatf("f%0d_res_l", n), 5'd6, 64'd1);
      chk($sformatf("f%0d_nack", n), 64'(bq.size()), 64'd0);
    end

    // 21! wraps: 21! mod 2^64 = 14197454024290336768
    wr(5'd4, 64'd21);
    wr(5'd0, 64'd1);
    wait_idle(500, cyc);
    chk("f21_lat", 64'(cyc), 64'd41);
    rd_chk("f21_opdone", 5'd2, 64'd3);
    rd_chk("f21_res_l",  5'd6, 64'hC507_7D36_B8C4_0000);

    // Injected high half: result_h readback, overflow flag, RO write ignored
    inject_h = 64'h1234;
    wr(5'd4, 64'd2);
    wr(5'd0, 64'd1);
    wait_idle(50, cyc);
    inject_h = '0;
    rd_chk("inj_res_h",  5'd5, 64'h1234);
    rd_chk("inj_res_l",  5'd6, 64'd2);
    rd_chk("inj_opdone", 5'd2, 64'd3);
    wr(5'd5, 64'hFFFF);
    rd_chk("ro_res_h",   5'd5, 64'h1234);
    rd_chk("unmapped",   5'd7, 64'd0);
    rd_chk("wo_opstart", 5'd0, 64'd0);
    rd_chk("operand_rb", 5'd4, 64'd2);

    // opstart and operand write while busy do not disturb the sequence
    ack_en = 1'b0;
    wr(5'd4, 64'd5);
    wr(5'd0, 64'd1);
    wait_req(20);
    wr(5'd4, 64'd3);
    wr(5'd0, 64'd1);
    ack_en = 1'b1;
    wait_idle(200, cyc);
    rd_chk("busy_res_l",   5'd6, 64'd120);
    rd_chk("busy_operand", 5'd4, 64'd3);

    // opclear during WAIT, then a stray ack
    ack_en = 1'b0;
    wr(5'd4, 64'd5);
    wr(5'd0, 64'd1);
    wait_req(20);
    wr(5'd1, 64'd1);
    chk("clr_req",  {63'd0, bus.mul_req}, 64'd0);
    chk("clr_busy", {63'd0, busy}, 64'd0);
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("clr_busy2", {63'd0, busy}, 64'd0);
    rd_chk("clr_res_l",   5'd6, 64'd0);
    rd_chk("clr_res_h",   5'd5, 64'd0);
    rd_chk("clr_opdone",  5'd2, 64'd0);
    rd_chk("clr_operand", 5'd4, 64'd5);
    ack_en = 1'b1;

    // Interrupt
    wr(5'd3, 64'd1);
    wr(5'd4, 64'd3);
    wr(5'd0, 64'd1);
    wait_idle(50, cyc);
`ifdef FACTO_INTR_EN
    chk("intr_set", {63'd0, intr}, 64'd1);
    rd_chk("intr_en_rb", 5'd3, 64'd1);
    wr(5'd1, 64'd1);
    chk("intr_clr", {63'd0, intr}, 64'd0);
`else
    chk("intr_off", {63'd0, intr}, 64'd0);
    rd_chk("intr_en_rb", 5'd3, 64'd0);
`endif
    rd_chk("f3_res_l", 5'd6, 64'd6);

    // Reset mid-operation aborts; a late ack is ignored
    ack_en = 1'b0;
    wr(5'd4, 64'd5);
    wr(5'd0, 64'd1);
    wait_req(20);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mrst_req",  {63'd0, bus.mul_req}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_b",    bus.mul_b, 64'd0);
    chk("mrst_intr", {63'd0, intr}, 64'd0);
    reset_n = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    chk("mrst_busy2", {63'd0, busy}, 64'd0);
    rd_chk("mrst_res_l",   5'd6, 64'd0);
    rd_chk("mrst_operand", 5'd4, 64'd0);
    ack_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
